// File: rtl/srl_pkg.sv
// Shared constants and state encoding for the iterative right shifter.
package srl_pkg;

  localparam int WIDTH     = 16;
  localparam int CNT_W     = 5;
  localparam int SHAMT_SAT = 16;
  localparam int STEP_N    = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/srl_iter_shifter_if.sv
// Start/busy/done handshake and operand/result bus of the iterative shifter.
interface srl_iter_shifter_if #(
  parameter int WIDTH = srl_pkg::WIDTH
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, arith, A, B,
    input  busy, done, result
  );

  modport slave (
    input  start, arith, A, B,
    output busy, done, result
  );
endinterface

// File: rtl/srl_step.sv
// One combinational right-shift step of 1 or STEP_N bits with a given fill bit.
module srl_step #(
  parameter int WIDTH = srl_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  input  logic             step4,
  output logic [WIDTH-1:0] shifted
);
  import srl_pkg::*;

  // Select between the single-bit and the wide step.
  always_comb begin
    shifted = data;
    if (step4) begin
      shifted = {{STEP_N{fill}}, data[WIDTH-1:STEP_N]};
    end else begin
      shifted = {fill, data[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/srl_iter_shifter.sv
// Multi-cycle logical/arithmetic right shifter with start/busy/done handshake.
// Define SRL_ITER_MULTISTEP_EN to shift 4 bits per cycle while at least 4 remain.
module srl_iter_shifter #(
  parameter int WIDTH = srl_pkg::WIDTH,
  parameter int CNT_W = srl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  srl_iter_shifter_if.slave bus
);
  import srl_pkg::*;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   data_nxt_s;
  logic               fill_r;
  logic               fill_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               step4_s;
  logic [CNT_W-1:0]   dec_s;
  logic [CNT_W-1:0]   n_sat_s;
  logic [WIDTH-1:0]   step_out_s;

  // Shift amounts of WIDTH or more all produce pure fill, so clamp to WIDTH.
  assign n_sat_s = (bus.B >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : bus.B[CNT_W-1:0];

`ifdef SRL_ITER_MULTISTEP_EN
  assign step4_s = (cnt_r >= CNT_W'(STEP_N));
`else
  assign step4_s = 1'b0;
`endif
  assign dec_s = step4_s ? CNT_W'(STEP_N) : CNT_W'(1);

  srl_step #(.WIDTH(WIDTH)) u_step (
    .data    (data_r),
    .fill    (fill_r),
    .step4   (step4_s),
    .shifted (step_out_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values; operands are only looked at in IDLE.
  always_comb begin
    data_nxt_s   = data_r;
    fill_nxt_s   = fill_r;
    cnt_nxt_s    = cnt_r;
    result_nxt_s = result_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          data_nxt_s = bus.A;
          fill_nxt_s = bus.arith & bus.A[WIDTH-1];
          cnt_nxt_s  = n_sat_s;
        end else begin
          data_nxt_s = data_r;
        end
      end
      SHIFT: begin
        if (cnt_r != CNT_W'(0)) begin
          data_nxt_s = step_out_s;
          cnt_nxt_s  = cnt_r - dec_s;
        end else begin
          result_nxt_s = data_r;
          done_nxt_s   = 1'b1;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == SHIFT);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= '0;
      fill_r   <= 1'b0;
      cnt_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      data_r   <= data_nxt_s;
      fill_r   <= fill_nxt_s;
      cnt_r    <= cnt_nxt_s;
      result_r <= result_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
endmodule
